instr_fetch_seq: RTL and testbench
==================================

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 Parameter INSTR_BYTES, default 4, bytes per instruction; legal range 1..8.
REQ-002 Parameter ADDR_W, default 32, width of PC and fetch address.
REQ-003 Parameter BIG_ENDIAN, default 1: 1 = first fetched byte is instr MSB; 0 = first fetched byte is instr LSB.
REQ-004 Parameter HALT_ON_ZERO, default 1: 1 = all-zero instruction halts the fetcher; 0 = all-zero instruction is dispatched like any other.
REQ-005 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 go  in  1  level enable; low forces the sequencer idle.
REQ-009 pc_rdata  in  ADDR_W  current PC value.
REQ-010 pc_wdata  out  ADDR_W  next-PC value written by the fetcher.
REQ-011 pc_wren  out  1  one-cycle PC write strobe.
REQ-012 fetch_addr  out  ADDR_W  registered byte address to instruction memory.
REQ-013 fetch_rdata  in  8  instruction byte for fetch_addr, valid in the cycle after fetch_addr changes.
REQ-014 instr  out  8*INSTR_BYTES  assembled instruction, stable while dec_run is high.
REQ-015 dec_run  out  1  instruction-valid request to the decoder.
REQ-016 dec_ok  in  1  decoder completion acknowledge.
REQ-017 finish  out  1  halted on zero instruction.
REQ-018 retired  out  CNT_W  count of instructions acknowledged by the decoder.

Function
REQ-019 States: IDLE, FETCH, CHECK, EXEC, HALT; all transitions on rising clk.
REQ-020 IDLE, go=1, finish=0: latch base=pc_rdata, fetch_addr<=pc_rdata, byte_cnt<=0, go to FETCH.
REQ-021 FETCH, each edge: shift fetch_rdata into instr per BIG_ENDIAN, fetch_addr<=fetch_addr+1, byte_cnt<=byte_cnt+1.
REQ-022 FETCH, edge sampling byte INSTR_BYTES-1: pc_wdata<=base+INSTR_BYTES, pc_wren<=1 for exactly one cycle, go to CHECK.
REQ-023 Address and PC arithmetic SHALL wrap modulo 2^ADDR_W (e.g. base 0xFFFFFFFF, 4 bytes -> addresses FFFFFFFF,0,1,2, pc_wdata=3).
REQ-024 CHECK: HALT_ON_ZERO=1 and instr==0 -> finish<=1, go to HALT; otherwise dec_run<=1, go to EXEC.
REQ-025 EXEC: hold dec_run=1 and instr constant until dec_ok sampled high; then dec_run<=0, retired<=retired+1, go to IDLE.
REQ-026 retired SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 dec_ok outside EXEC SHALL be ignored.
REQ-028 Latency: go-accepting edge to dec_run high = INSTR_BYTES+2 edges; minimum issue period = INSTR_BYTES+3 edges with dec_ok already high.
REQ-029 pc_wren SHALL never be high while dec_run is high (decoder owns PC writes during EXEC).
REQ-030 HALT: hold finish=1; leave only when go=0.
REQ-031 go=0 in any state: next edge -> IDLE, dec_run=0, pc_wren=0, finish=0; instr and retired retained; partial fetch discarded, PC not written.
REQ-032 IDLE re-reads pc_rdata each fetch so decoder PC writes (jumps) take effect on the next instruction.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and set fetch_addr, pc_wdata, instr, byte_cnt, retired to 0 and pc_wren, dec_run, finish to 0, independent of clk.
REQ-034 Reset assertion mid-FETCH or mid-EXEC SHALL abandon the operation with no PC write and no retired increment.

Verification
REQ-035 Default params, pc=0x10, bytes 12,34,56,78, dec_ok after 2 cycles -> fetch_addr 10..13, instr=0x12345678, pc_wren pulse with 0x14, retired=1.
REQ-036 BIG_ENDIAN=0, same bytes -> instr=0x78563412.
REQ-037 HALT_ON_ZERO=1, bytes 00,00,00,00 -> finish=1, dec_run never high, pc_wdata=base+4; drop go -> finish=0 next edge.
REQ-038 pc=0xFFFFFFFF -> fetch_addr FFFFFFFF,0,1,2, pc_wdata=0x00000003.
REQ-039 go dropped after 2 bytes, then reasserted -> no pc_wren, refetch restarts at unchanged pc_rdata; rst_n pulse during EXEC -> dec_run=0 asynchronously, retired=0.
REQ-040 CNT_W=2, five instructions retired -> retired stays at 3.

Source files
------------

// File: rtl/instr_fetch_seq_if.sv
// Bus bundle between the instruction fetch sequencer, its PC register, instruction
// memory and decoder. The master modport is the sequencer side.
interface instr_fetch_seq_if #(
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 16
) ();
    logic                     go;
    logic [ADDR_W-1:0]        pc_rdata;
    logic [ADDR_W-1:0]        pc_wdata;
    logic                     pc_wren;
    logic [ADDR_W-1:0]        fetch_addr;
    logic [7:0]               fetch_rdata;
    logic [8*INSTR_BYTES-1:0] instr;
    logic                     dec_run;
    logic                     dec_ok;
    logic                     finish;
    logic [CNT_W-1:0]         retired;

    modport master (
        input  go, pc_rdata, fetch_rdata, dec_ok,
        output pc_wdata, pc_wren, fetch_addr, instr, dec_run, finish, retired
    );

    modport slave (
        output go, pc_rdata, fetch_rdata, dec_ok,
        input  pc_wdata, pc_wren, fetch_addr, instr, dec_run, finish, retired
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Byte-serial instruction fetch sequencer: reads INSTR_BYTES bytes from the PC, advances
// the PC, then hands the assembled instruction to the decoder and waits for its ack.
module instr_fetch_seq #(
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter bit          BIG_ENDIAN   = 1'b1,
    parameter bit          HALT_ON_ZERO = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_seq_if.master bus
);
    localparam int unsigned IW  = 8 * INSTR_BYTES;
    localparam int unsigned BCW = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [BCW-1:0] LastByte = BCW'(INSTR_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StCheck, StExec, StHalt} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] pc_wdata_q, pc_wdata_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]     shift_q, shift_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              pc_wren_q, pc_wren_d;
    logic              dec_run_q, dec_run_d;
    logic              finish_q, finish_d;
    logic [IW-1:0]     shift_next;

    // Bytes assemble in a shadow register so an aborted fetch leaves instr untouched.
    if (INSTR_BYTES == 1) begin : g_one_byte
        assign shift_next = bus.fetch_rdata;
    end else if (BIG_ENDIAN) begin : g_big_endian
        assign shift_next = {shift_q[IW-9:0], bus.fetch_rdata};
    end else begin : g_little_endian
        assign shift_next = {bus.fetch_rdata, shift_q[IW-1:8]};
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        base_d       = base_q;
        pc_wdata_d   = pc_wdata_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        pc_wren_d    = 1'b0;
        dec_run_d    = dec_run_q;
        finish_d     = finish_q;

        if (!bus.go) begin
            state_d   = StIdle;
            dec_run_d = 1'b0;
            finish_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!finish_q) begin
                        base_d       = bus.pc_rdata;
                        fetch_addr_d = bus.pc_rdata;
                        byte_cnt_d   = '0;
                        state_d      = StFetch;
                    end
                end
                StFetch: begin
                    shift_d      = shift_next;
                    fetch_addr_d = fetch_addr_q + 1'b1;
                    byte_cnt_d   = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LastByte) begin
                        instr_d    = shift_next;
                        pc_wdata_d = base_q + ADDR_W'(INSTR_BYTES);
                        pc_wren_d  = 1'b1;
                        state_d    = StCheck;
                    end
                end
                StCheck: begin
                    if (HALT_ON_ZERO && (instr_q == '0)) begin
                        finish_d = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        dec_run_d = 1'b1;
                        state_d   = StExec;
                    end
                end
                StExec: begin
                    if (bus.dec_ok) begin
                        dec_run_d = 1'b0;
                        if (retired_q != '1) begin
                            retired_d = retired_q + 1'b1;
                        end
                        state_d = StIdle;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_addr_q <= '0;
            base_q       <= '0;
            pc_wdata_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            instr_q      <= '0;
            retired_q    <= '0;
            pc_wren_q    <= 1'b0;
            dec_run_q    <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            base_q       <= base_d;
            pc_wdata_q   <= pc_wdata_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            pc_wren_q    <= pc_wren_d;
            dec_run_q    <= dec_run_d;
            finish_q     <= finish_d;
        end
    end

    assign bus.fetch_addr = fetch_addr_q;
    assign bus.pc_wdata   = pc_wdata_q;
    assign bus.pc_wren    = pc_wren_q;
    assign bus.instr      = instr_q;
    assign bus.dec_run    = dec_run_q;
    assign bus.finish     = finish_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: a default instance and a little-endian, no-halt, 2-bit counter
// instance run in lockstep against a byte-memory model of the expected instruction stream.
module tb_instr_fetch_seq;
    localparam int IB = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        go     = 1'b0;
    logic        dec_ok = 1'b0;
    logic [31:0] pc     = '0;
    logic [7:0]  mem [256];

    int n_run  = 0;
    int n_fail = 0;
    int n_ret  = 0;

    instr_fetch_seq_if #(.INSTR_BYTES(IB), .ADDR_W(32), .CNT_W(16)) ifa ();
    instr_fetch_seq_if #(.INSTR_BYTES(IB), .ADDR_W(32), .CNT_W(2))  ifb ();

    assign ifa.go          = go;
    assign ifa.pc_rdata    = pc;
    assign ifa.dec_ok      = dec_ok;
    assign ifa.fetch_rdata = mem[ifa.fetch_addr[7:0]];
    assign ifb.go          = go;
    assign ifb.pc_rdata    = pc;
    assign ifb.dec_ok      = dec_ok;
    assign ifb.fetch_rdata = mem[ifb.fetch_addr[7:0]];

    instr_fetch_seq #(
        .INSTR_BYTES(IB), .ADDR_W(32), .BIG_ENDIAN(1'b1), .HALT_ON_ZERO(1'b1), .CNT_W(16)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    instr_fetch_seq #(
        .INSTR_BYTES(IB), .ADDR_W(32), .BIG_ENDIAN(1'b0), .HALT_ON_ZERO(1'b0), .CNT_W(2)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_instr(input logic [31:0] base, input bit be);
        logic [31:0] v = '0;
        logic [31:0] a;
        for (int i = 0; i < IB; i++) begin
            a = base + 32'(i);
            if (be) v = v | (32'(mem[a[7:0]]) << (8 * (IB - 1 - i)));
            else    v = v | (32'(mem[a[7:0]]) << (8 * i));
        end
        return v;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic fill_instr(input logic [31:0] base);
        logic [31:0] a;
        for (int i = 0; i < IB; i++) begin
            a = base + 32'(i);
            mem[a[7:0]] = 8'($urandom_range(1, 255));
        end
    endtask

    // Observations of one instruction issued by run_instr
    logic [31:0] obs_addr [IB];
    logic [31:0] obs_ia, obs_ib, obs_wa, obs_wb;
    logic [15:0] obs_ra;
    logic [1:0]  obs_rb;
    int          obs_lat, obs_wren;
    bit          obs_overlap, obs_unstable, obs_timeout;

    // Starts with go raised in IDLE; returns at the sample after dec_run falls (or finish).
    task automatic run_instr(input int ok_delay, input bit do_jump, input logic [31:0] jump_pc);
        int cyc = 0;
        int hi  = 0;
        bit done = 1'b0;
        obs_lat = 0; obs_wren = 0; obs_overlap = 0; obs_unstable = 0;
        obs_ia = 'x; obs_ib = 'x; obs_wa = 'x; obs_wb = 'x;
        go = 1'b1;
        dec_ok = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc <= IB) obs_addr[cyc-1] = ifa.fetch_addr;
            if ((ifa.pc_wren && ifa.dec_run) || (ifb.pc_wren && ifb.dec_run)) obs_overlap = 1;
            if (ifa.pc_wren) begin
                obs_wren++;
                obs_wa = ifa.pc_wdata;
                obs_wb = ifb.pc_wdata;
                pc     = ifa.pc_wdata;
            end
            if (ifa.dec_run) begin
                if (hi == 0) begin
                    obs_lat = cyc;
                    obs_ia  = ifa.instr;
                    obs_ib  = ifb.instr;
                    if (do_jump) pc = jump_pc;
                end else if (ifa.instr !== obs_ia || ifb.instr !== obs_ib) begin
                    obs_unstable = 1;
                end
                hi++;
                if (hi > ok_delay) dec_ok = 1'b1;
            end else if (hi > 0 || ifa.finish) begin
                done = 1'b1;
            end
        end
        dec_ok = 1'b0;
        obs_timeout = !done;
        obs_ra = ifa.retired;
        obs_rb = ifb.retired;
    endtask

    task automatic go_idle();
        go = 1'b0;
        dec_ok = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if (ifa.fetch_addr !== 32'h0 || ifa.pc_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_a: got fa=%h pw=%h expected 0", ifa.fetch_addr, ifa.pc_wdata);
        end
        n_run++;
        if ({ifa.pc_wren, ifa.dec_run, ifa.finish} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags_a: got %b expected 000",
                     {ifa.pc_wren, ifa.dec_run, ifa.finish});
        end
        n_run++;
        if (ifa.instr !== 32'h0 || ifa.retired !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data_a: got instr=%h ret=%h expected 0", ifa.instr, ifa.retired);
        end
        n_run++;
        if ({ifb.pc_wren, ifb.dec_run, ifb.finish, ifb.retired, ifb.instr} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_all_b: got ret=%h instr=%h expected 0", ifb.retired, ifb.instr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        go_idle();
        pc = 32'h10;
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        run_instr(2, 1'b0, 32'h0);
        n_ret++;
        n_run++;
        if (obs_timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
        for (int i = 0; i < IB; i++) begin
            n_run++;
            if (obs_addr[i] !== 32'h10 + 32'(i)) begin
                n_fail++;
                $display("FAIL basic_addr%0d: got %h expected %h", i, obs_addr[i], 32'h10 + 32'(i));
            end
        end
        n_run++;
        if (obs_ia !== 32'h12345678) begin
            n_fail++; $display("FAIL basic_instr_be: got %h expected 12345678", obs_ia);
        end
        n_run++;
        if (obs_ib !== 32'h78563412) begin
            n_fail++; $display("FAIL basic_instr_le: got %h expected 78563412", obs_ib);
        end
        n_run++;
        if (obs_wren !== 1 || obs_wa !== 32'h14) begin
            n_fail++; $display("FAIL basic_pc_write: got %0d x %h expected 1 x 14", obs_wren, obs_wa);
        end
        n_run++;
        if (obs_lat !== IB + 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected %0d", obs_lat, IB + 2);
        end
        n_run++;
        if (obs_ra !== 16'd1 || obs_rb !== 2'd1) begin
            n_fail++; $display("FAIL basic_retired: got %0d/%0d expected 1/1", obs_ra, obs_rb);
        end
        n_run++;
        if (obs_overlap || obs_unstable) begin
            n_fail++;
            $display("FAIL basic_protocol: got overlap=%0d unstable=%0d expected 0/0",
                     obs_overlap, obs_unstable);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] base = 32'hFFFF_FFFF;
        go_idle();
        pc = base;
        fill_instr(base);
        run_instr(0, 1'b0, 32'h0);
        n_ret++;
        for (int i = 0; i < IB; i++) begin
            n_run++;
            if (obs_addr[i] !== base + 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %h expected %h", i, obs_addr[i], base + 32'(i));
            end
        end
        n_run++;
        if (obs_wa !== 32'h3 || obs_wb !== 32'h3) begin
            n_fail++; $display("FAIL wrap_pc: got %h/%h expected 00000003", obs_wa, obs_wb);
        end
        n_run++;
        if (obs_ia !== model_instr(base, 1) || obs_ib !== model_instr(base, 0)) begin
            n_fail++;
            $display("FAIL wrap_instr: got %h/%h expected %h/%h", obs_ia, obs_ib,
                     model_instr(base, 1), model_instr(base, 0));
        end
    endtask

    task automatic test_random();
        logic [31:0] base, jpc, ea, eb;
        int dly;
        bit jmp;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) pc = $urandom;
            base = pc;
            fill_instr(base);
            ea  = model_instr(base, 1);
            eb  = model_instr(base, 0);
            dly = $urandom_range(0, 3);
            jmp = 1'($urandom_range(0, 1));
            jpc = $urandom;
            run_instr(dly, jmp, jpc);
            n_ret++;
            n_run++;
            if (obs_timeout || obs_overlap || obs_unstable) begin
                n_fail++;
                $display("FAIL rand%0d_protocol: got to=%0d ov=%0d un=%0d expected 0/0/0",
                         it, obs_timeout, obs_overlap, obs_unstable);
            end
            n_run++;
            if (obs_addr[0] !== base || obs_addr[IB-1] !== base + 32'(IB - 1)) begin
                n_fail++;
                $display("FAIL rand%0d_addr: got %h..%h expected %h..%h", it, obs_addr[0],
                         obs_addr[IB-1], base, base + 32'(IB - 1));
            end
            n_run++;
            if (obs_ia !== ea || obs_ib !== eb) begin
                n_fail++;
                $display("FAIL rand%0d_instr: got %h/%h expected %h/%h", it, obs_ia, obs_ib, ea, eb);
            end
            n_run++;
            if (obs_wren !== 1 || obs_wa !== base + 32'(IB) || obs_wb !== base + 32'(IB)) begin
                n_fail++;
                $display("FAIL rand%0d_pc: got %0d x %h/%h expected 1 x %h", it, obs_wren,
                         obs_wa, obs_wb, base + 32'(IB));
            end
            n_run++;
            if (obs_lat !== IB + 2) begin
                n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, obs_lat, IB + 2);
            end
            n_run++;
            if (obs_ra !== 16'(sat(n_ret, 65535)) || obs_rb !== 2'(sat(n_ret, 3))) begin
                n_fail++;
                $display("FAIL rand%0d_retired: got %0d/%0d expected %0d/%0d", it, obs_ra, obs_rb,
                         sat(n_ret, 65535), sat(n_ret, 3));
            end
        end
    endtask

    // dec_ok held high throughout: issue period is the minimum, and stray acks are ignored.
    task automatic test_back_to_back();
        int rises = 0;
        int first = 0;
        int last  = 0;
        bit prev  = 1'b0;
        bit ovl   = 1'b0;
        go_idle();
        dec_ok = 1'b1;
        go = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            if (ifa.pc_wren && ifa.dec_run) ovl = 1'b1;
            if (ifa.pc_wren) pc = ifa.pc_wdata;
            if (ifa.dec_run && !prev) begin
                rises++;
                if (rises == 1) begin
                    first = cyc;
                end else begin
                    n_run++;
                    if (cyc - last !== IB + 3) begin
                        n_fail++;
                        $display("FAIL b2b_period: got %0d expected %0d", cyc - last, IB + 3);
                    end
                end
                last = cyc;
            end
            prev = ifa.dec_run;
        end
        n_ret += 4;
        n_run++;
        if (rises !== 4 || first !== IB + 2) begin
            n_fail++;
            $display("FAIL b2b_issue: got %0d issues first@%0d expected 4 first@%0d",
                     rises, first, IB + 2);
        end
        n_run++;
        if (ifa.retired !== 16'(sat(n_ret, 65535)) || ifb.retired !== 2'(sat(n_ret, 3))) begin
            n_fail++;
            $display("FAIL b2b_retired: got %0d/%0d expected %0d/%0d", ifa.retired, ifb.retired,
                     sat(n_ret, 65535), sat(n_ret, 3));
        end
        n_run++;
        if (ovl) begin n_fail++; $display("FAIL b2b_overlap: got pc_wren with dec_run expected none"); end
        go_idle();
    endtask

    task automatic test_go_drop();
        logic [31:0] base, prev_a, prev_b;
        int wren = 0;
        go_idle();
        base = pc;
        fill_instr(base);
        prev_a = ifa.instr;
        prev_b = ifb.instr;
        go = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) go = 1'b0;
            @(posedge clk);
            #1;
            if (ifa.pc_wren || ifb.pc_wren) wren++;
        end
        n_run++;
        if (wren !== 0 || ifa.dec_run !== 1'b0 || ifa.finish !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_abort: got wren=%0d run=%b fin=%b expected 0/0/0",
                     wren, ifa.dec_run, ifa.finish);
        end
        n_run++;
        if (ifa.instr !== prev_a || ifb.instr !== prev_b) begin
            n_fail++;
            $display("FAIL drop_instr_kept: got %h/%h expected %h/%h", ifa.instr, ifb.instr,
                     prev_a, prev_b);
        end
        n_run++;
        if (ifa.retired !== 16'(sat(n_ret, 65535)) || ifb.retired !== 2'(sat(n_ret, 3))) begin
            n_fail++;
            $display("FAIL drop_retired: got %0d/%0d expected %0d/%0d", ifa.retired, ifb.retired,
                     sat(n_ret, 65535), sat(n_ret, 3));
        end
        @(posedge clk);
        #1;
        run_instr(1, 1'b0, 32'h0);
        n_ret++;
        n_run++;
        if (obs_addr[0] !== base || obs_wren !== 1 || obs_wa !== base + 32'(IB)) begin
            n_fail++;
            $display("FAIL drop_refetch: got start=%h wren=%0d pw=%h expected %h 1 %h",
                     obs_addr[0], obs_wren, obs_wa, base, base + 32'(IB));
        end
        n_run++;
        if (obs_ia !== model_instr(base, 1)) begin
            n_fail++;
            $display("FAIL drop_instr: got %h expected %h", obs_ia, model_instr(base, 1));
        end
    endtask

    task automatic test_halt();
        logic [31:0] base, a;
        logic [31:0] wa = 'x;
        int fin_at = 0;
        bit a_run  = 1'b0;
        bit b_run  = 1'b0;
        go_idle();
        base = pc;
        for (int i = 0; i < IB; i++) begin
            a = base + 32'(i);
            mem[a[7:0]] = 8'h00;
        end
        go = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (ifa.dec_run) a_run = 1'b1;
            if (ifb.dec_run) b_run = 1'b1;
            if (ifa.finish && fin_at == 0) fin_at = cyc;
            if (ifa.pc_wren) begin
                wa = ifa.pc_wdata;
                pc = ifa.pc_wdata;
            end
        end
        n_run++;
        if (ifa.finish !== 1'b1 || fin_at !== IB + 2) begin
            n_fail++;
            $display("FAIL halt_finish: got fin=%b at %0d expected 1 at %0d", ifa.finish, fin_at, IB + 2);
        end
        n_run++;
        if (a_run) begin n_fail++; $display("FAIL halt_no_run: got dec_run high expected low"); end
        n_run++;
        if (wa !== base + 32'(IB)) begin
            n_fail++; $display("FAIL halt_pc: got %h expected %h", wa, base + 32'(IB));
        end
        n_run++;
        if (!b_run || ifb.instr !== 32'h0 || ifb.finish !== 1'b0) begin
            n_fail++;
            $display("FAIL nohalt_dispatch: got run=%0d instr=%h fin=%b expected 1 0 0",
                     b_run, ifb.instr, ifb.finish);
        end
        go_idle();
        n_run++;
        if (ifa.finish !== 1'b0 || ifb.dec_run !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_release: got fin=%b runb=%b expected 0/0", ifa.finish, ifb.dec_run);
        end
        n_run++;
        if (ifa.retired !== 16'(sat(n_ret, 65535)) || ifb.retired !== 2'(sat(n_ret, 3))) begin
            n_fail++;
            $display("FAIL halt_retired: got %0d/%0d expected %0d/%0d", ifa.retired, ifb.retired,
                     sat(n_ret, 65535), sat(n_ret, 3));
        end
        fill_instr(base);
    endtask

    task automatic test_reset_mid();
        int wren = 0;
        int cyc  = 0;
        go_idle();
        go = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_run++;
        if (ifa.fetch_addr !== 32'h0 || ifa.instr !== 32'h0 || ifb.instr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_fetch: got fa=%h instr=%h/%h expected 0", ifa.fetch_addr,
                     ifa.instr, ifb.instr);
        end
        go = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ifa.pc_wren || ifb.pc_wren) wren++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ifa.pc_wren || ifb.pc_wren) wren++;
        end
        n_run++;
        if (wren !== 0) begin n_fail++; $display("FAIL rst_fetch_nowrite: got %0d expected 0", wren); end
        n_ret = 0;
        go = 1'b1;
        dec_ok = 1'b0;
        while (!ifa.dec_run && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ifa.pc_wren) pc = ifa.pc_wdata;
        end
        n_run++;
        if (ifa.dec_run !== 1'b1) begin
            n_fail++; $display("FAIL rst_exec_reach: got dec_run=%b expected 1", ifa.dec_run);
        end
        #3 rst_n = 1'b0;
        #1;
        n_run++;
        if (ifa.dec_run !== 1'b0 || ifb.dec_run !== 1'b0 || ifa.pc_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_async: got run=%b/%b wren=%b expected 0", ifa.dec_run,
                     ifb.dec_run, ifa.pc_wren);
        end
        n_run++;
        if (ifa.retired !== 16'h0 || ifb.retired !== 2'h0) begin
            n_fail++;
            $display("FAIL rst_exec_retired: got %0d/%0d expected 0/0", ifa.retired, ifb.retired);
        end
        go = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        go_idle();
        for (int i = 1; i <= 5; i++) begin
            fill_instr(pc);
            run_instr(0, 1'b0, 32'h0);
            n_ret++;
            n_run++;
            if (obs_ra !== 16'(i) || obs_rb !== 2'(sat(i, 3))) begin
                n_fail++;
                $display("FAIL sat%0d_retired: got %0d/%0d expected %0d/%0d", i, obs_ra, obs_rb,
                         i, sat(i, 3));
            end
        end
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_back_to_back();
        test_go_drop();
        test_halt();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
